// File: rtl/eth_rx_pkg.sv
// Shared widths and enums for the Ethernet receive frame source.
package eth_rx_pkg;

  localparam int ETH_DATA_W = 64;
  localparam int ETH_KEEP_W = 8;
  localparam int ENTRY_W    = ETH_DATA_W + ETH_KEEP_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DISCARD
  } wr_state_t;

  typedef enum logic [1:0] {
    DROP_ERR,
    DROP_RUNT,
    DROP_OVF
  } drop_cause_t;

endpackage

// File: rtl/eth_rx_buf_ram.sv
// Simple dual-port frame storage, one write port and one synchronous read port.
module eth_rx_buf_ram
  import eth_rx_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                       clock,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0]         wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [ENTRY_W-1:0]         rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_rx_frame_source.sv
// Store-and-forward MAC receive buffer: drops errored/runt/overflowed frames, streams good ones.
// Optional frame statistics counters are built when ETH_RX_STATS_EN is defined.
//
// state   | meaning
// IDLE    | between frames, next valid beat starts a frame
// RECV    | storing beats of the current frame
// DISCARD | frame overflowed, ignoring beats until tlast
module eth_rx_frame_source
  import eth_rx_pkg::*;
#(
  parameter int DEPTH     = 512,
  parameter int MIN_BEATS = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [63:0]              s_axis_tdata,
  input  logic [7:0]               s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tvalid,
  output logic [63:0]              m_axis_tdata,
  output logic [7:0]               m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     drop_pulse,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              stat_ok,
  output logic [31:0]              stat_err,
  output logic [31:0]              stat_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MIN_BEATS + 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [CW-1:0] MIN_P   = CW'(MIN_BEATS);

  wr_state_t     state, state_nxt;
  drop_cause_t   cause;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt, commit_ptr, commit_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt, fetch_ptr, used;
  logic [CW-1:0] cnt, cnt_nxt, cnt_base, cnt_inc;
  logic          full, wr_en, drop, commit;

  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == DEPTH_P);
  assign cnt_base = (state == IDLE) ? '0 : cnt;
  assign cnt_inc  = (cnt_base >= MIN_P) ? cnt_base : cnt_base + CW'(1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    cnt_nxt    = cnt;
    wr_en      = 1'b0;
    drop       = 1'b0;
    commit     = 1'b0;
    cause      = DROP_ERR;
    case (state)
      IDLE, RECV: begin
        if (s_axis_tvalid) begin
          if (full) begin
            cause = DROP_OVF;
            if (s_axis_tlast) begin
              drop       = 1'b1;
              wr_ptr_nxt = commit_ptr;
              state_nxt  = IDLE;
            end else begin
              state_nxt = DISCARD;
            end
          end else begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(1);
            cnt_nxt    = cnt_inc;
            state_nxt  = RECV;
            if (s_axis_tlast) begin
              state_nxt = IDLE;
              if (!s_axis_tuser && (cnt_inc >= MIN_P)) begin
                commit     = 1'b1;
                commit_nxt = wr_ptr + PW'(1);
              end else begin
                drop       = 1'b1;
                wr_ptr_nxt = commit_ptr;
                cause      = s_axis_tuser ? DROP_ERR : DROP_RUNT;
              end
            end
          end
        end
      end
      DISCARD: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          drop       = 1'b1;
          cause      = DROP_OVF;
          wr_ptr_nxt = commit_ptr;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      cnt        <= '0;
      drop_pulse <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_nxt;
      cnt        <= cnt_nxt;
      drop_pulse <= drop;
    end
  end

  logic [ENTRY_W-1:0] ram_rdata;
  logic [ENTRY_W-1:0] sk [2];
  logic [1:0]         sk_cnt;
  logic [2:0]         occ;
  logic               hd, rd_pend, fetch, pop;

  eth_rx_buf_ram #(.DEPTH(DEPTH)) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .rd_en   (fetch),
    .rd_addr (fetch_ptr[AW-1:0]),
    .rd_data (ram_rdata)
  );

  // occ is the skid occupancy after this cycle, counting a read still in the RAM pipe
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign occ        = {1'b0, sk_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign fetch      = (fetch_ptr != commit_ptr) && (occ < 3'd2);
  assign rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;

  assign m_axis_tvalid = (sk_cnt != 2'd0);
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = sk[hd];
  assign m_axis_tuser  = 1'b0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr    <= '0;
      fetch_ptr <= '0;
      rd_pend   <= 1'b0;
      hd        <= 1'b0;
      sk_cnt    <= 2'd0;
      sk[0]     <= '0;
      sk[1]     <= '0;
      level     <= '0;
    end else begin
      rd_pend <= fetch;
      rd_ptr  <= rd_ptr_nxt;
      sk_cnt  <= occ[1:0];
      level   <= commit_nxt - rd_ptr_nxt;
      if (fetch)   fetch_ptr <= fetch_ptr + PW'(1);
      if (pop)     hd <= ~hd;
      if (rd_pend) sk[hd ^ sk_cnt[0]] <= ram_rdata;
    end
  end

`ifdef ETH_RX_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_ok  <= '0;
      stat_err <= '0;
      stat_ovf <= '0;
    end else begin
      if (commit && (stat_ok != '1)) stat_ok <= stat_ok + 32'd1;
      if (drop && (cause != DROP_OVF) && (stat_err != '1)) stat_err <= stat_err + 32'd1;
      if (drop && (cause == DROP_OVF) && (stat_ovf != '1)) stat_ovf <= stat_ovf + 32'd1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = ^{commit, cause};
  assign stat_ok  = '0;
  assign stat_err = '0;
  assign stat_ovf = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_source.sv
// Randomized bench for eth_rx_frame_source with a frame-level scoreboard model.
module tb_eth_rx_frame_source;

  localparam int DEPTH     = 256;
  localparam int MIN_BEATS = 8;

  logic        clock, resetn;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast, s_axis_tuser, s_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tuser, m_axis_tvalid, m_axis_tready;
  logic        drop_pulse;
  logic [8:0]  level;
  logic [31:0] stat_ok, stat_err, stat_ovf;

  eth_rx_frame_source #(.DEPTH(DEPTH), .MIN_BEATS(MIN_BEATS)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .drop_pulse    (drop_pulse),
    .level         (level),
    .stat_ok       (stat_ok),
    .stat_err      (stat_err),
    .stat_ovf      (stat_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // frame-level reference: frames are accepted whole or not at all
  logic [72:0] exp_q[$];
  logic [72:0] cur_q[$];
  logic [72:0] out_ent, in_ent, prev_ent, e;
  bit          disc, prev_stall;
  int          stored, m_ok, m_err, m_ovf, m_drops, dut_drops, out_beats;
  bit          rdy_rand, rdy_fix;

  assign out_ent = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
  assign in_ent  = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  always @(negedge clock) begin
    if (resetn) begin
      if (drop_pulse) dut_drops++;
      if (s_axis_tvalid) begin
        if (disc) begin
          if (s_axis_tlast) begin
            disc = 0; cur_q.delete(); m_ovf++; m_drops++;
          end
        end else if (stored + cur_q.size() == DEPTH) begin
          if (s_axis_tlast) begin
            cur_q.delete(); m_ovf++; m_drops++;
          end else disc = 1;
        end else begin
          cur_q.push_back(in_ent);
          if (s_axis_tlast) begin
            if (!s_axis_tuser && cur_q.size() >= MIN_BEATS) begin
              foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
              stored += cur_q.size();
              m_ok++;
            end else begin
              m_err++; m_drops++;
            end
            cur_q.delete();
          end
        end
      end
      if (prev_stall) begin
        check("stall_valid", 80'(m_axis_tvalid), 80'(1));
        check("stall_hold", 80'(out_ent), 80'(prev_ent));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        if (exp_q.size() == 0) check("spurious_beat", 80'(m_axis_tvalid), 80'(0));
        else begin
          e = exp_q.pop_front();
          stored--;
          check("beat", 80'({m_axis_tuser, out_ent}), 80'({1'b0, e}));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_ent   = out_ent;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clock); #1;
      m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  function automatic logic [31:0] exp_stat(input int v);
`ifdef ETH_RX_STATS_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic assert_reset();
    resetn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    exp_q.delete(); cur_q.delete();
    disc = 0; stored = 0; m_ok = 0; m_err = 0; m_ovf = 0; m_drops = 0; dut_drops = 0;
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    @(posedge clock); #1;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
  endtask

  // tuser on non-last beats is noise the DUT must ignore
  task automatic send_frame(input int len, input logic err);
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) drive_beat({$urandom, $urandom}, 8'($urandom_range(1, 255)), 1'b1, err);
      else drive_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    rdy_rand = 0; rdy_fix = 1;
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    check(tag, 80'(exp_q.size()), 80'(0));
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, 80'(level), 80'(stored));
    check({tag, "_drops"}, 80'(dut_drops), 80'(m_drops));
    check({tag, "_stat_ok"}, 80'(stat_ok), 80'(exp_stat(m_ok)));
    check({tag, "_stat_err"}, 80'(stat_err), 80'(exp_stat(m_err)));
    check({tag, "_stat_ovf"}, 80'(stat_ovf), 80'(exp_stat(m_ovf)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int lat, ob;

  initial begin
    rdy_rand = 0; rdy_fix = 1; out_beats = 0; prev_stall = 0;
    s_axis_tdata = '0; s_axis_tkeep = '0;
    assert_reset();
    release_reset();
    @(negedge clock);
    check("rst_tvalid", 80'(m_axis_tvalid), 80'(0));
    check_state("rst");

    // single good 64-byte frame, latency from tlast to tvalid
    ob = out_beats;
    send_frame(8, 1'b0);
    @(posedge clock); #1 s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    lat = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      if (m_axis_tvalid) begin lat = n; break; end
      @(posedge clock);
    end
    check("latency_le3", 80'(lat >= 1 && lat <= 3), 80'(1));
    drain("good_drain");
    check("good_beats", 80'(out_beats - ob), 80'(8));
    check_state("good");

    // errored frame then good frame
    ob = out_beats;
    send_frame(16, 1'b1);
    send_frame(8, 1'b0);
    idle(3);
    drain("err_drain");
    check("err_beats", 80'(out_beats - ob), 80'(8));
    check_state("err");

    // runt
    ob = out_beats;
    send_frame(4, 1'b0);
    idle(4);
    drain("runt_drain");
    check("runt_beats", 80'(out_beats - ob), 80'(0));
    check_state("runt");

    // overflow with consumer stalled
    rdy_fix = 0;
    idle(2);
    send_frame(200, 1'b0);
    send_frame(100, 1'b0);
    idle(5);
    check("ovf_level200", 80'(level), 80'(200));
    check("ovf_tvalid", 80'(m_axis_tvalid), 80'(1));
    check_state("ovf");
    ob = out_beats;
    drain("ovf_drain");
    check("ovf_beats", 80'(out_beats - ob), 80'(200));
    check_state("ovf_after");

    // back-to-back random traffic with random backpressure
    rdy_rand = 1;
    for (int f = 0; f < 1000; f++) send_frame(9, 1'($urandom_range(0, 7) == 0));
    idle(2);
    drain("rand_drain");
    check_state("rand");

    // reset mid-frame with one frame committed
    rdy_fix = 0;
    idle(2);
    send_frame(8, 1'b0);
    idle(3);
    for (int i = 0; i < 5; i++) drive_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
    #2;
    assert_reset();
    #1;
    check("mrst_tvalid", 80'(m_axis_tvalid), 80'(0));
    check("mrst_entry", 80'(out_ent), 80'(0));
    check("mrst_level", 80'(level), 80'(0));
    check("mrst_drop", 80'(drop_pulse), 80'(0));
    release_reset();
    rdy_fix = 1;
    ob = out_beats;
    send_frame(8, 1'b0);
    idle(3);
    drain("mrst_drain");
    check("mrst_beats", 80'(out_beats - ob), 80'(8));
    check_state("mrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
